// File: rtl/display_pkg.sv
// Frame buffer geometry, fill FSM encoding and rectangle command type
// shared by the display-side CPU accelerators.
package display_pkg;
  localparam int FB_W      = 320;
  localparam int FB_H      = 240;
  localparam int FB_ADDR_W = 17;
  localparam int COLOR_W   = 12;

  typedef enum logic [1:0] {IDLE, SETUP, FILL} fill_state_e;

  typedef struct packed {
    logic [8:0] x;
    logic [7:0] y;
    logic [8:0] w;
    logic [7:0] h;
  } rect_t;
endpackage

// File: rtl/fb_rect_clip.sv
// Combinational clip of a rectangle to the frame buffer, with empty detect.
// Ends are exclusive; sums are 10 bits wide so large x+w never wraps.
module fb_rect_clip
  import display_pkg::*;
#(
  parameter int FB_W = display_pkg::FB_W,
  parameter int FB_H = display_pkg::FB_H
) (
  input  rect_t      rect,
  output logic [8:0] x_end,
  output logic [7:0] y_end,
  output logic       empty
);
  localparam logic [9:0] W10 = 10'(FB_W);
  localparam logic [9:0] H10 = 10'(FB_H);

  logic [9:0] x_sum, y_sum;

  assign x_sum = {1'b0, rect.x} + {1'b0, rect.w};
  assign y_sum = {2'b0, rect.y} + {2'b0, rect.h};
  assign x_end = (x_sum > W10) ? W10[8:0] : x_sum[8:0];
  assign y_end = (y_sum > H10) ? H10[7:0] : y_sum[7:0];
  assign empty = (rect.w == '0) || (rect.h == '0) ||
                 ({1'b0, rect.x} >= W10) || ({2'b0, rect.y} >= H10);
endmodule

// File: rtl/fb_rect_fill.sv
// Rectangle fill engine: latches a command, clips it in SETUP, then streams
// one registered pixel write per granted cycle in row-major order.
module fb_rect_fill
  import display_pkg::*;
#(
  parameter int FB_W = display_pkg::FB_W,
  parameter int FB_H = display_pkg::FB_H
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic [8:0]           rect_x,
  input  logic [7:0]           rect_y,
  input  logic [8:0]           rect_w,
  input  logic [7:0]           rect_h,
  input  logic [COLOR_W-1:0]   color,
  input  logic                 fb_grant,
  output logic                 fb_write,
  output logic [FB_ADDR_W-1:0] fb_addr,
  output logic [31:0]          fb_wdata,
  output logic                 busy,
  output logic                 done
);
  localparam logic [FB_ADDR_W-1:0] FBW_A = FB_ADDR_W'(FB_W);

  fill_state_e          state_q, state_d;
  rect_t                rect_q;
  logic [COLOR_W-1:0]   color_q;
  logic [8:0]           x_end, x_last_q, col_q;
  logic [7:0]           y_end, y_last_q, row_q;
  logic                 empty, last_col, last_px;
  logic [FB_ADDR_W-1:0] row_base_q, row_base0;

  fb_rect_clip #(.FB_W(FB_W), .FB_H(FB_H)) u_clip (
    .rect  (rect_q),
    .x_end (x_end),
    .y_end (y_end),
    .empty (empty)
  );

  // y*FB_W as a sum of shifted copies over the set bits of the constant
  always_comb begin
    row_base0 = '0;
    for (int i = 0; i < FB_ADDR_W; i++)
      if (FBW_A[i]) row_base0 = row_base0 + (FB_ADDR_W'(rect_q.y) << i);
  end

  assign last_col = (col_q == x_last_q);
  assign last_px  = last_col && (row_q == y_last_q);

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = SETUP;
      SETUP:   state_d = (abort || empty) ? IDLE : FILL;
      FILL:    if (abort || (fb_grant && last_px)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rect_q     <= '0;
      color_q    <= '0;
      x_last_q   <= '0;
      y_last_q   <= '0;
      col_q      <= '0;
      row_q      <= '0;
      row_base_q <= '0;
      fb_write   <= 1'b0;
      fb_addr    <= '0;
      fb_wdata   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_q)
        IDLE: if (start) begin
          rect_q  <= '{x: rect_x, y: rect_y, w: rect_w, h: rect_h};
          color_q <= color;
          busy    <= 1'b1;
        end
        SETUP: begin
          if (abort) begin
            busy <= 1'b0;
          end else if (empty) begin
            busy <= 1'b0;
            done <= 1'b1;
          end else begin
            x_last_q   <= x_end - 9'd1;
            y_last_q   <= y_end - 8'd1;
            col_q      <= rect_q.x;
            row_q      <= rect_q.y;
            row_base_q <= row_base0;
            fb_addr    <= row_base0 + FB_ADDR_W'(rect_q.x);
            fb_wdata   <= {{(32-COLOR_W){1'b0}}, color_q};
            fb_write   <= 1'b1;
          end
        end
        FILL: begin
          // abort beats a completing grant: no done pulse on a cancelled fill
          if (abort) begin
            fb_write <= 1'b0;
            busy     <= 1'b0;
          end else if (fb_grant) begin
            if (last_px) begin
              fb_write <= 1'b0;
              busy     <= 1'b0;
              done     <= 1'b1;
            end else if (last_col) begin
              col_q      <= rect_q.x;
              row_q      <= row_q + 8'd1;
              row_base_q <= row_base_q + FBW_A;
              fb_addr    <= row_base_q + FBW_A + FB_ADDR_W'(rect_q.x);
            end else begin
              col_q   <= col_q + 9'd1;
              fb_addr <= fb_addr + 17'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_fb_rect_fill.sv
// Directed bench for fb_rect_fill: table of fills with hand-computed
// results, plus backpressure, abort, reset and start-while-busy sequences.
module tb_fb_rect_fill;
  logic        clk, reset_n, start, abort, fb_grant;
  logic [8:0]  rect_x, rect_w;
  logic [7:0]  rect_y, rect_h;
  logic [11:0] color;
  logic        fb_write, busy, done;
  logic [16:0] fb_addr;
  logic [31:0] fb_wdata;

  fb_rect_fill dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
    .rect_x(rect_x), .rect_y(rect_y), .rect_w(rect_w), .rect_h(rect_h),
    .color(color), .fb_grant(fb_grant), .fb_write(fb_write),
    .fb_addr(fb_addr), .fb_wdata(fb_wdata), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int x, y, w, h, col;
    int n, first, last, lat;
  } vec_t;

  int n_cmp = 0, n_bad = 0;
  int cyc = 0, start_cyc = 0, done_cyc = 0, done_cnt = 0, busy_cnt = 0;
  logic [16:0] wq[$], exp_q[$], wr_log[$];
  logic [31:0] wd_q[$];

  // Monitor: granted writes, every presented address, done/busy timing
  always @(negedge clk) begin
    cyc++;
    if (start && !busy) start_cyc = cyc;
    if (fb_write) wr_log.push_back(fb_addr);
    if (fb_write && fb_grant) begin
      wq.push_back(fb_addr);
      wd_q.push_back(fb_wdata);
    end
    if (done) begin done_cnt++; done_cyc = cyc; end
    if (busy) busy_cnt++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Independent row-major reference of the clipped pixel addresses
  task automatic build_exp(input int x, input int y, input int w, input int h);
    int xe, ye;
    exp_q.delete();
    xe = (x + w > 320) ? 320 : x + w;
    ye = (y + h > 240) ? 240 : y + h;
    for (int yy = y; yy < ye; yy++)
      for (int xx = x; xx < xe; xx++)
        exp_q.push_back(17'(yy * 320 + xx));
  endtask

  task automatic start_cmd(input int x, input int y, input int w, input int h, input int c);
    @(posedge clk); #1;
    wq.delete(); wd_q.delete(); wr_log.delete();
    done_cnt = 0; busy_cnt = 0;
    rect_x = 9'(x); rect_y = 8'(y); rect_w = 9'(w); rect_h = 8'(h);
    color = 12'(c); fb_grant = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    bit ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!busy) begin ok = 1; break; end
    end
    if (!ok) begin
      n_cmp++; n_bad++;
      $display("FAIL timeout: busy still 1 after %0d cycles, expected 0", budget);
    end
    @(posedge clk); #1;
  endtask

  task automatic chk_seq(input string name);
    int bad = 0;
    chk({name, "_count"}, wq.size(), exp_q.size());
    for (int i = 0; i < wq.size() && i < exp_q.size(); i++)
      if (wq[i] !== exp_q[i]) bad++;
    chk({name, "_addr_seq_errs"}, bad, 0);
  endtask

  task automatic chk_wdata(input string name, input int c);
    int bad = 0;
    foreach (wd_q[i]) if (wd_q[i] !== {20'b0, 12'(c)}) bad++;
    chk({name, "_wdata_errs"}, bad, 0);
  endtask

  task automatic run_vec(input vec_t v, input string name);
    build_exp(v.x, v.y, v.w, v.h);
    start_cmd(v.x, v.y, v.w, v.h, v.col);
    wait_idle(v.n + 40);
    chk({name, "_writes"}, wq.size(), v.n);
    if (v.n > 0) begin
      chk({name, "_first"}, wq[0], v.first);
      chk({name, "_last"}, wq[wq.size()-1], v.last);
    end
    chk_seq(name);
    chk_wdata(name, v.col);
    chk({name, "_done_cnt"}, done_cnt, 1);
    chk({name, "_done_lat"}, done_cyc - start_cyc, v.lat);
    chk({name, "_busy_cycles"}, busy_cnt, v.lat - 1);
    begin
      int over = 0;
      foreach (wr_log[i]) if (wr_log[i] > 17'd76799) over++;
      chk({name, "_addr_over_max"}, over, 0);
    end
  endtask

  vec_t tbl[9];
  int   gpat[7];
  logic [16:0] bp_log[7];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{x:10,  y:5,   w:3,   h:2,  col:'hF00, n:6,   first:1610,  last:1932,  lat:8};
    tbl[1] = '{x:318, y:238, w:10,  h:10, col:'h0AB, n:4,   first:76478, last:76799, lat:6};
    tbl[2] = '{x:5,   y:5,   w:0,   h:3,  col:'h111, n:0,   first:0,     last:0,     lat:2};
    tbl[3] = '{x:320, y:0,   w:5,   h:5,  col:'h222, n:0,   first:0,     last:0,     lat:2};
    tbl[4] = '{x:7,   y:9,   w:4,   h:0,  col:'h333, n:0,   first:0,     last:0,     lat:2};
    tbl[5] = '{x:0,   y:240, w:4,   h:4,  col:'h444, n:0,   first:0,     last:0,     lat:2};
    tbl[6] = '{x:0,   y:239, w:320, h:1,  col:'hFFF, n:320, first:76480, last:76799, lat:322};
    tbl[7] = '{x:300, y:10,  w:511, h:3,  col:'h5A5, n:60,  first:3500,  last:4159,  lat:62};
    tbl[8] = '{x:319, y:0,   w:1,   h:1,  col:'h001, n:1,   first:319,   last:319,   lat:3};
    gpat   = '{1, 0, 0, 1, 1, 0, 1};
    bp_log = '{17'd0, 17'd1, 17'd1, 17'd1, 17'd2, 17'd3, 17'd3};

    reset_n = 1'b0; start = 1'b0; abort = 1'b0; fb_grant = 1'b1;
    rect_x = '0; rect_y = '0; rect_w = '0; rect_h = '0; color = '0;
    #12;
    chk("rst_fb_write", fb_write, 0);
    chk("rst_fb_addr", fb_addr, 0);
    chk("rst_fb_wdata", fb_wdata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    @(posedge clk); #1 reset_n = 1'b1;

    for (int i = 0; i < 9; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

    // Backpressure: address must hold while grant is low
    build_exp(0, 0, 4, 1);
    start_cmd(0, 0, 4, 1, 'h777);
    for (int i = 0; i < 7; i++) begin
      @(posedge clk); #1 fb_grant = gpat[i][0];
    end
    @(posedge clk); #1 fb_grant = 1'b1;
    wait_idle(20);
    chk_seq("bp");
    chk("bp_presented", wr_log.size(), 7);
    begin
      int bad = 0;
      for (int i = 0; i < 7 && i < wr_log.size(); i++) if (wr_log[i] !== bp_log[i]) bad++;
      chk("bp_hold_errs", bad, 0);
    end
    chk("bp_done_lat", done_cyc - start_cyc, 9);
    chk("bp_done_cnt", done_cnt, 1);

    // Abort during the 3rd write of a 100x1 fill
    build_exp(0, 0, 3, 1);
    start_cmd(0, 0, 100, 1, 'h0C0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_fb_write", fb_write, 0);
    repeat (4) @(posedge clk);
    #1;
    chk_seq("abort");
    chk("abort_done_cnt", done_cnt, 0);

    // Reset mid-fill, then a normal fill
    start_cmd(0, 1, 100, 1, 'h123);
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b0;
    #2;
    chk("mrst_fb_write", fb_write, 0);
    chk("mrst_fb_addr", fb_addr, 0);
    chk("mrst_fb_wdata", fb_wdata, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_done", done, 0);
    @(posedge clk); #1 reset_n = 1'b1;
    begin
      vec_t v;
      v = '{x:2, y:0, w:2, h:1, col:'h0AB, n:2, first:2, last:3, lat:4};
      run_vec(v, "post_rst");
    end

    // Second start mid-fill is ignored
    build_exp(10, 5, 3, 2);
    start_cmd(10, 5, 3, 2, 'hF00);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rect_x = 9'd0; rect_y = 8'd0; rect_w = 9'd50; rect_h = 8'd50; color = 12'h0F0;
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_idle(40);
    chk_seq("sbusy");
    chk_wdata("sbusy", 'hF00);
    chk("sbusy_done_lat", done_cyc - start_cyc, 8);
    chk("sbusy_done_cnt", done_cnt, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
